// File: rtl/add64_seq_arbiter.sv
// Two-requester 64-bit adder built from one shared 32-bit slice.
// Round-robin grant, low half then high half, result held until the consumer takes it.
module thirty_two_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [31:0] sum
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module add64_seq_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovrflow
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        id;
  } req_t;

  state_t      state, state_nx;
  req_t        op;
  logic        last_gnt;
  logic        grant;
  logic        any_req;
  logic        c1;
  logic [31:0] sum_lo;
  logic [31:0] s_a, s_b, s_sum;
  logic        s_cin, s_cout;

  // Both valid: alternate away from last grantee; otherwise whoever is valid.
  assign any_req = req0_valid | req1_valid;
  assign grant   = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;

  // Gated by rst_n so neither ready can assert while reset holds state at IDLE.
  assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = rst_n & (state == IDLE) & req1_valid &  grant;
  assign rsp_valid  = (state == DONE);

  always_comb begin
    s_a   = op.a[31:0];
    s_b   = op.b[31:0];
    s_cin = 1'b0;
    if (state == HI) begin
      s_a   = op.a[63:32];
      s_b   = op.b[63:32];
      s_cin = c1;
    end
  end

  thirty_two_bit_adder u_slice (
    .a   (s_a),
    .b   (s_b),
    .cin (s_cin),
    .cout(s_cout),
    .sum (s_sum)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = LO;
      LO:      state_nx = HI;
      HI:      state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      op          <= '0;
      c1          <= 1'b0;
      sum_lo      <= '0;
      rsp_id      <= 1'b0;
      rsp_sum     <= '0;
      rsp_cout    <= 1'b0;
      rsp_ovrflow <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any_req) begin
          op.a     <= grant ? req1_a : req0_a;
          op.b     <= grant ? req1_b : req0_b;
          op.id    <= grant;
          last_gnt <= grant;
        end
        LO: begin
          sum_lo <= s_sum;
          c1     <= s_cout;
        end
        HI: begin
          rsp_sum     <= {s_sum, sum_lo};
          rsp_cout    <= s_cout;
          rsp_ovrflow <= (~s_sum[31] & op.a[63] & op.b[63]) |
                         ( s_sum[31] & ~op.a[63] & ~op.b[63]);
          rsp_id      <= op.id;
        end
        default: ;
      endcase
    end
  end
endmodule
